// File: rtl/gray_word_packer.sv
// rtl/gray_word_packer.sv - packs four 8-bit grayscale pixels per 32-bit word into a tagged FWFT FIFO
//
// Purpose: raster-tracks an unthrottled pixel stream and packs pixels x[1:0]=0..3
// into one word (pixel 0 in [7:0]). Each word carries sof/eol/eof flags. Words are
// buffered in a first-word-fall-through FIFO that feeds a ready/valid consumer.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   frame_sync                 pulse marking pixel (0,0) of a new frame
//   pixel_in, pixel_in_valid   pixel stream, always accepted
//   word_out, word_out_sof/eol/eof, word_out_valid, word_out_ready   word stream
//   overflow                   sticky: a completed word was dropped on a full FIFO
module gray_word_packer #(
  parameter int FRAME_WIDTH  = 1280,
  parameter int FRAME_HEIGHT = 720,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_sync,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic [31:0] word_out,
  output logic        word_out_sof,
  output logic        word_out_eol,
  output logic        word_out_eof,
  output logic        word_out_valid,
  input  logic        word_out_ready,
  output logic        overflow
);

  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  logic [7:0]    lane0, lane1, lane2;

  logic [34:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [34:0]   rd_data;

  logic push, pop, push_ok, full;
  logic sof, eol, eof;

  // frame_sync re-bases the position for the pixel arriving in the same cycle,
  // so that pixel lands in lane 0 as (0,0) and any partial word is abandoned.
  always_comb begin
    cur_x = x;
    cur_y = y;
    if (frame_sync) begin
      cur_x = '0;
      cur_y = '0;
    end
  end

  assign eol  = (cur_x == X_LAST);
  assign eof  = eol && (cur_y == Y_LAST);
  assign sof  = (cur_y == '0) && (cur_x == XW'(3));

  assign full    = (count == FULL_COUNT);
  assign push    = pixel_in_valid && (cur_x[1:0] == 2'd3);
  assign pop     = word_out_valid && word_out_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      lane0 <= '0;
      lane1 <= '0;
      lane2 <= '0;
    end else if (pixel_in_valid) begin
      case (cur_x[1:0])
        2'd0:    lane0 <= pixel_in;
        2'd1:    lane1 <= pixel_in;
        2'd2:    lane2 <= pixel_in;
        default: ;
      endcase
      if (eol) begin
        x <= '0;
        y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
      end else begin
        x <= cur_x + 1'b1;
        y <= cur_y;
      end
    end else if (frame_sync) begin
      x <= '0;
      y <= '0;
    end
  end

  // Storage needs no reset: outputs are masked by word_out_valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {eof, eol, sof, pixel_in, lane2, lane1, lane0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A frame_sync cycle never completes a word, so clear and set cannot collide.
      if (frame_sync)         overflow <= 1'b0;
      else if (push && !push_ok) overflow <= 1'b1;
    end
  end

  assign word_out_valid = (count != '0);
  assign rd_data        = mem[rd_ptr];
  assign word_out       = word_out_valid ? rd_data[31:0] : 32'h0;
  assign word_out_sof   = word_out_valid && rd_data[32];
  assign word_out_eol   = word_out_valid && rd_data[33];
  assign word_out_eof   = word_out_valid && rd_data[34];

endmodule

// File: tb/tb_gray_word_packer.sv
// tb/tb_gray_word_packer.sv - directed self-checking bench for gray_word_packer
module tb_gray_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_sync = 1'b0;
  logic [7:0]  pixel_in = 8'h0;
  logic        pixel_in_valid = 1'b0;
  logic [31:0] word_out;
  logic        word_out_sof, word_out_eol, word_out_eof;
  logic        word_out_valid;
  logic        word_out_ready = 1'b1;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  // Expected words/flags {sof,eol,eof} for a 0x01..0x10 frame of 8x2.
  logic [31:0] exp_word [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
  logic [2:0]  exp_flag [4] = '{3'b100, 3'b010, 3'b000, 3'b011};

  gray_word_packer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .frame_sync(frame_sync),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .word_out(word_out), .word_out_sof(word_out_sof), .word_out_eol(word_out_eol),
    .word_out_eof(word_out_eof), .word_out_valid(word_out_valid),
    .word_out_ready(word_out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic fs);
    pixel_in = p;
    pixel_in_valid = 1'b1;
    frame_sync = fs;
    tick();
    pixel_in_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic [2:0] f);
    check({tag, "_valid"}, 32'(word_out_valid), 32'd1);
    check({tag, "_word"}, word_out, w);
    check({tag, "_flags"}, 32'({word_out_sof, word_out_eol, word_out_eof}), 32'(f));
  endtask

  // Sends 0x01..0x10 with ready high; optional idle cycle after each pixel.
  task automatic run_stream(input string tag, input logic fs_first, input logic gapped);
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), fs_first && (i == 1));
      if (i % 4 == 0) check_word(tag, exp_word[i/4 - 1], exp_flag[i/4 - 1]);
      else            check({tag, "_novalid"}, 32'(word_out_valid), 32'd0);
      if (gapped) begin
        tick();
        check({tag, "_gap_novalid"}, 32'(word_out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset_valid", 32'(word_out_valid), 32'd0);
    check("reset_word", word_out, 32'h0);
    check("reset_flags", 32'({word_out_sof, word_out_eol, word_out_eof}), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Basic packing, then the next frame's first word.
    run_stream("basic", 1'b0, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    check_word("basic_next_frame", 32'hDDCCBBAA, 3'b100);
    tick();
    check("basic_drained", 32'(word_out_valid), 32'd0);

    // Gapped input.
    run_stream("gapped", 1'b1, 1'b1);

    // Backpressure and overflow: 5 words into a 4-deep FIFO.
    word_out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), i == 1);
      if (i == 19) check("bp_overflow_pre", 32'(overflow), 32'd0);
    end
    check("bp_overflow_set", 32'(overflow), 32'd1);
    check_word("bp_hold", 32'h04030201, 3'b100);
    word_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_word("bp_drain", exp_word[k], exp_flag[k]);
      tick();
    end
    check("bp_empty", 32'(word_out_valid), 32'd0);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with push and pop on the same edge.
    word_out_ready = 1'b0;
    send(8'h01, 1'b1);
    check("full_sync_clears_overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 16; i++) send(8'(i), 1'b0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    word_out_ready = 1'b1;
    send(8'h24, 1'b0);
    check("full_pp_overflow", 32'(overflow), 32'd0);
    check_word("full_pp_w2", 32'h08070605, 3'b010);
    tick();
    check_word("full_pp_w3", 32'h0C0B0A09, 3'b000);
    tick();
    check_word("full_pp_w4", 32'h100F0E0D, 3'b011);
    tick();
    check_word("full_pp_w5", 32'h24232221, 3'b100);
    tick();
    check("full_pp_empty", 32'(word_out_valid), 32'd0);

    // frame_sync mid-word, with overflow set beforehand.
    word_out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(8'(i), i == 1);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    check("fs_overflow_set", 32'(overflow), 32'd1);
    word_out_ready = 1'b1;
    send(8'h55, 1'b1);
    check("fs_overflow_cleared", 32'(overflow), 32'd0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check_word("fs_word", 32'h88776655, 3'b100);
    tick();
    check("fs_empty", 32'(word_out_valid), 32'd0);

    // Asynchronous reset with 3 words buffered.
    word_out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) send(8'(i), i == 1);
    check("ar_buffered", 32'(word_out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(word_out_valid), 32'd0);
    check("ar_word", word_out, 32'h0);
    check("ar_flags", 32'({word_out_sof, word_out_eol, word_out_eof}), 32'd0);
    tick();
    reset = 1'b0;
    word_out_ready = 1'b1;
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b0);
    check_word("ar_after", 32'hA4A3A2A1, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_word_packer.md
# gray_word_packer

Downstream consumer of the grayscale converter. Takes the 8-bit grayscale pixel stream (one pixel per valid cycle, no backpressure) and packs four consecutive pixels into one 32-bit word. It tags each word with frame-position flags and buffers the words in a small FIFO that drives a ready/valid interface toward the memory writer. It tracks position with raster counters, flags any data loss, and stays aligned to frames via an external frame-sync pulse.

## Interface
- FRAME_WIDTH, 1280: pixels per line; must be a multiple of 4.
- FRAME_HEIGHT, 720: lines per frame.
- FIFO_DEPTH, 8: words of buffering; power of 2, at least 2.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_sync  in  1  single-cycle pulse marking the first pixel of a new frame.
- pixel_in  in  8  grayscale pixel.
- pixel_in_valid  in  1  pixel_in is valid this cycle; always accepted.
- word_out  out  32  packed word; pixel 0 (earliest) in [7:0], pixel 3 in [31:24].
- word_out_sof  out  1  word is the first word of a frame (x=0, y=0).
- word_out_eol  out  1  word is the last word of a line.
- word_out_eof  out  1  word is the last word of a frame (implies eol).
- word_out_valid  out  1  FIFO non-empty; word_out and flags valid.
- word_out_ready  in  1  consumer accepts the word when valid and ready are both high.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
- Counters:
  - x counts 0..FRAME_WIDTH-1, y counts 0..FRAME_HEIGHT-1; both advance per accepted pixel.
  - x wraps to 0 and y increments at end of line; both wrap to 0 after the last pixel of the frame.
- Packing:
  - Pixels with x[1:0] = 0..2 are held in lane registers.
  - The pixel with x[1:0] = 3 completes the word, which is written to the FIFO in the same edge with its flags:
    - sof = (y==0 && x==3)
    - eol = (x==FRAME_WIDTH-1)
    - eof = eol && (y==FRAME_HEIGHT-1)
- frame_sync:
  - Forces x=0, y=0 and discards any partially assembled word.
  - If pixel_in_valid is high in the same cycle, that pixel is pixel (0,0) of the new frame.
  - Clears overflow. FIFO contents are unaffected.
- FIFO:
  - First-word-fall-through; outputs driven from storage registers with no combinational path from pixel_in.
  - Pop when word_out_valid && word_out_ready.
- Full FIFO:
  - A push with no simultaneous pop drops the new word; overflow sets. Counters still advance, so alignment is preserved.
  - Push and pop in the same cycle while full both succeed; nothing is dropped.
- Empty FIFO: word_out_ready is ignored.
- No state machine beyond the counters and FIFO pointers; fill count ranges 0..FIFO_DEPTH.

## Timing
- Reset values:
  - word_out = 0, all flags = 0, word_out_valid = 0, overflow = 0.
  - Counters, lanes and FIFO pointers = 0.
- Reset asserted mid-frame:
  - All buffered words are lost; outputs return to reset values immediately (asynchronous).
  - After reset, the next pixel is treated as (0,0).
- Latency: with the FIFO empty, the 4th pixel of a group sampled at edge k gives word_out_valid = 1 with the word visible immediately after edge k. One-cycle pass-through.
- Throughput: one word per 4 valid pixels. Sustained drain needs ready at least 25% of cycles when input is continuous.
- overflow asserts on the edge that drops the word and holds until reset or frame_sync.
- word_out is stable while word_out_valid && !word_out_ready.

## Test plan
Bench parameters: FRAME_WIDTH=8, FRAME_HEIGHT=2, FIFO_DEPTH=4.

- Basic packing, ready held 1:
  - Stimulus: reset, then pixels 0x01..0x10 streamed contiguously.
  - Required: words 0x04030201 (sof), 0x08070605 (eol), 0x0C0B0A09, 0x100F0E0D (eol, eof); each valid the cycle after its 4th pixel.
  - Then a 17th pixel 0xAA followed by 0xBB,0xCC,0xDD gives 0xDDCCBBAA with sof.
- Gapped input:
  - Stimulus: same stream as above, pixel_in_valid toggling 1/0.
  - Required: identical words and flags; no word emitted on invalid cycles.
- Backpressure and overflow:
  - Stimulus: ready=0 while 20 pixels are sent (5 words).
  - Required: words 1–4 buffered; word 5 dropped; overflow rises on the 20th-pixel edge.
  - Then ready=1: 4 words drain in order; overflow stays 1.
- Full push plus pop:
  - Stimulus: FIFO full, ready=1 on the exact cycle the next word completes.
  - Required: no drop, overflow stays 0, order preserved.
- frame_sync mid-word:
  - Stimulus: 6 pixels, then frame_sync together with pixel 0x55, then 0x66,0x77,0x88.
  - Required: the partial word (pixels 5–6) is discarded; next word is 0x88776655 with sof; overflow cleared.
- Async reset mid-drain:
  - Stimulus: assert reset between edges with 3 words buffered.
  - Required: word_out_valid=0, word_out=0 and flags 0 immediately; after release, the next 4 pixels produce a word with sof.
